rom_stream_loader: RTL and testbench
====================================

ROM_STREAM_LOADER -- requirements
Module: rom_stream_loader

Interface
REQ-001 Parameters: SDR_BYTES, default 1048576, size in bytes of the SDRAM region at the bottom of the load address space (even, at most 2^25).
REQ-002 Parameters: NUM_BRAM, default 6, number of BRAM regions stacked above SDR_BYTES, range 1..8.
REQ-003 Parameters: BRAM_AW, default 16, byte-address width of each BRAM region; each region holds 2^BRAM_AW bytes.
REQ-004 Clock and reset: one clock and one reset. Reset is asynchronous and active-low.
REQ-005 Port: CLK, input, 1 bit, system clock; every register updates on its rising edge.
REQ-006 Port: RSTn, input, 1 bit, asynchronous active-low reset.
REQ-007 Port: ioctl_download, input, 1 bit, high for the duration of a load.
REQ-008 Port: ioctl_wr, input, 1 bit, one-cycle byte strobe.
REQ-009 Port: ioctl_addr, input, 25 bits, load byte address.
REQ-010 Port: ioctl_data, input, 8 bits, load byte.
REQ-011 Port: ioctl_wait, output, 1 bit, host shall not strobe ioctl_wr while this is high.
REQ-012 Port: sdr_addr, output, 25 bits, byte address of the word being written; bit 0 is always 0.
REQ-013 Port: sdr_data, output, 16 bits, write word.
REQ-014 Port: sdr_be, output, 2 bits, byte enables; bit 0 = low byte.
REQ-015 Port: sdr_req, output, 1 bit, write request level.
REQ-016 Port: sdr_rdy, input, 1 bit, one-cycle completion pulse.
REQ-017 Port: bram_addr, output, BRAM_AW bits, byte offset within the selected region.
REQ-018 Port: bram_data, output, 8 bits, BRAM write byte.
REQ-019 Port: bram_cs, output, NUM_BRAM bits, one-hot region select.
REQ-020 Port: bram_wr, output, 1 bit, one-cycle BRAM write pulse.
REQ-021 Port: load_done, output, 1 bit, one-cycle pulse when a load has fully drained.
REQ-022 Port: err, output, 2 bits, sticky error flags: bit 0 = address out of range, bit 1 = write received while ioctl_wait was high.

Function
REQ-023 Address decode: an address a < SDR_BYTES selects SDRAM; otherwise idx = (a - SDR_BYTES) >> BRAM_AW selects BRAM region idx when idx < NUM_BRAM; any other address is out of range.
REQ-024 An out-of-range byte shall be dropped and shall set err[0].
REQ-025 The block shall implement the FSM states IDLE, HOLD, REQ and FLUSH.
REQ-026 Packing is little-endian: an even address fills the low byte and an odd address fills the high byte of the word at address a & ~1.
REQ-027 IDLE, SDRAM byte at an even address: latch the byte as the low byte, set be=01 and go to HOLD; no request is issued.
REQ-028 IDLE, SDRAM byte at an odd address: latch the byte as the high byte, set be=10 and go to REQ.
REQ-029 HOLD, odd byte for the same word: merge it, set be=11 and go to REQ.
REQ-030 HOLD, SDRAM byte for a different word, or a BRAM byte: issue the held partial word (be=01) first via REQ, then apply the new byte once that write completes.
REQ-031 HOLD, falling edge of ioctl_download: go to FLUSH and issue the held partial word.
REQ-032 sdr_req shall rise in the cycle after the transition into REQ or FLUSH.
REQ-033 sdr_addr, sdr_data and sdr_be shall be stable while sdr_req is high.
REQ-034 sdr_req shall drop in the cycle after sdr_rdy; the FSM then returns to IDLE, or applies the pending byte.
REQ-035 sdr_rdy while sdr_req is low shall be ignored.
REQ-036 ioctl_wait shall be high in REQ and FLUSH and whenever a byte is pending; it shall be low otherwise.
REQ-037 A write arriving while ioctl_wait is high shall be dropped and shall set err[1].
REQ-038 BRAM write: the cycle after ioctl_wr, bram_wr pulses with bram_cs one-hot at idx, bram_addr = offset[BRAM_AW-1:0] and bram_data = the byte.
REQ-039 bram_cs shall be all-zero when bram_wr is low.
REQ-040 load_done shall pulse one cycle after ioctl_download is low with the FSM in IDLE and no byte pending, once per falling edge of ioctl_download.
REQ-041 A falling edge of ioctl_download in IDLE yields load_done two cycles after the edge.
REQ-042 A rising edge of ioctl_download shall clear err.
REQ-043 ioctl_wr while ioctl_download is low shall be ignored.

Reset
REQ-044 RSTn low shall asynchronously force: FSM to IDLE, sdr_req=0, sdr_be=00, sdr_addr=0, sdr_data=0, bram_wr=0, bram_cs=0, bram_addr=0, bram_data=0, ioctl_wait=0, load_done=0, err=00.
REQ-045 Reset asserted mid-request shall abandon that request and discard any held byte; no partial word is issued after release.

Verification
REQ-046 Bytes 0x11@0x0, 0x22@0x1 -> exactly one write: sdr_addr=0x0, sdr_data=0x2211, be=11; ioctl_wait high until the cycle after sdr_rdy.
REQ-047 Byte 0xAB@0x4, then download falls -> FLUSH write: addr=0x4, data low byte=0xAB, be=01; load_done pulses once after sdr_rdy.
REQ-048 Bytes 0x01@0x2, then 0x02@0x8 -> partial write (addr 0x2, be=01) first, then 0x02 held; the sdr_addr sequence is 0x2, then 0x8.
REQ-049 Byte 0x5A@SDR_BYTES+2*2^16+3 with defaults -> bram_wr pulse, bram_cs=000100, bram_addr=0x0003, bram_data=0x5A; no sdr_req.
REQ-050 Byte @SDR_BYTES+6*2^16 -> err=01, no bram_wr, no sdr_req; a write strobed while ioctl_wait=1 -> err=11.
REQ-051 RSTn pulsed low while sdr_req=1 -> all outputs 0 within the same cycle; no request after release until new bytes arrive.

Source files
------------

// File: rtl/rom_stream_loader.sv
// ROM stream loader: turns a byte-serial ioctl download into 16-bit SDRAM
// word writes (little-endian packing) and direct BRAM byte writes.
//
// state | meaning
// IDLE  | no word held; next byte (pending one first) is decoded here
// HOLD  | low byte of an SDRAM word held, waiting for its odd partner
// REQ   | SDRAM word write outstanding during the load
// FLUSH | held partial word written after ioctl_download dropped
module rom_stream_loader #(
   parameter int SDR_BYTES = 1048576,
   parameter int NUM_BRAM  = 6,
   parameter int BRAM_AW   = 16
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                ioctl_download,
   input  logic                ioctl_wr,
   input  logic [24:0]         ioctl_addr,
   input  logic [7:0]          ioctl_data,
   output logic                ioctl_wait,
   output logic [24:0]         sdr_addr,
   output logic [15:0]         sdr_data,
   output logic [1:0]          sdr_be,
   output logic                sdr_req,
   input  logic                sdr_rdy,
   output logic [BRAM_AW-1:0]  bram_addr,
   output logic [7:0]          bram_data,
   output logic [NUM_BRAM-1:0] bram_cs,
   output logic                bram_wr,
   output logic                load_done,
   output logic [1:0]          err
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REQ, S_FLUSH} state_t;

   localparam logic [25:0] SDR_L = 26'(SDR_BYTES);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [24:0]         r_sdr_addr;
   logic [15:0]         r_sdr_data;
   logic [1:0]          r_sdr_be;
   logic                r_sdr_req;
   logic                r_pend;
   logic [24:0]         r_pend_addr;
   logic [7:0]          r_pend_data;
   logic                r_bram_wr;
   logic [NUM_BRAM-1:0] r_bram_cs;
   logic [BRAM_AW-1:0]  r_bram_addr;
   logic [7:0]          r_bram_data;
   logic                r_load_done;
   logic                r_done_arm;
   logic [1:0]          r_err;
   logic                r_dl_d;

   logic                w_wait;
   logic                w_strobe;
   logic                w_accept;
   logic                w_drop;
   logic                w_src_pend;
   logic                w_b_vld;
   logic [24:0]         w_b_addr;
   logic [7:0]          w_b_data;
   logic [25:0]         w_off;
   logic [25:0]         w_idx;
   logic                w_is_sdr;
   logic                w_is_bram;
   logic [NUM_BRAM-1:0] w_cs;
   logic                w_same_word;
   logic                w_dl_fall;
   logic                w_dl_rise;
   logic                w_done;
   logic                w_ld_even;
   logic                w_ld_odd;
   logic                w_merge;
   logic                w_pend_set;
   logic                w_pend_clr;
   logic                w_do_bram;
   logic                w_err_rng;

   // The host is held off while a write is outstanding or a byte is parked.
   assign w_wait     = (r_state == S_REQ) || (r_state == S_FLUSH) || r_pend;
   assign w_strobe   = ioctl_download && ioctl_wr;
   assign w_accept   = w_strobe && !w_wait;
   assign w_drop     = w_strobe && w_wait;
   // A parked byte is replayed in IDLE before anything new is accepted.
   assign w_src_pend = (r_state == S_IDLE) && r_pend;
   assign w_b_vld    = w_src_pend || w_accept;
   assign w_b_addr   = w_src_pend ? r_pend_addr : ioctl_addr;
   assign w_b_data   = w_src_pend ? r_pend_data : ioctl_data;

   assign w_is_sdr    = {1'b0, w_b_addr} < SDR_L;
   assign w_off       = {1'b0, w_b_addr} - SDR_L;
   assign w_idx       = w_off >> BRAM_AW;
   assign w_is_bram   = !w_is_sdr && (w_idx < 26'(NUM_BRAM));
   assign w_same_word = w_b_addr[24:1] == r_sdr_addr[24:1];

   assign w_dl_fall = r_dl_d && !ioctl_download;
   assign w_dl_rise = !r_dl_d && ioctl_download;
   assign w_done    = r_done_arm && !ioctl_download && (r_state == S_IDLE) && !r_pend;

   // One-hot region select for the decoded BRAM index.
   always_comb begin
      w_cs = '0;
      for (int i = 0; i < NUM_BRAM; i++) begin
         w_cs[i] = (w_idx == 26'(i));
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and datapath control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_even   = 1'b0;
      w_ld_odd    = 1'b0;
      w_merge     = 1'b0;
      w_pend_set  = 1'b0;
      w_pend_clr  = 1'b0;
      w_do_bram   = 1'b0;
      w_err_rng   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pend_clr = w_src_pend;
            if (w_b_vld) begin
               if (w_is_sdr) begin
                  if (!w_b_addr[0]) begin
                     w_ld_even   = 1'b1;
                     w_state_nxt = S_HOLD;
                  end else begin
                     w_ld_odd    = 1'b1;
                     w_state_nxt = S_REQ;
                  end
               end else if (w_is_bram) begin
                  w_do_bram = 1'b1;
               end else begin
                  w_err_rng = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (w_accept) begin
               if (w_is_sdr && w_same_word && w_b_addr[0]) begin
                  w_merge     = 1'b1;
                  w_state_nxt = S_REQ;
               end else if (w_is_sdr && w_same_word) begin
                  // Rewrite of the held low byte; keep holding.
                  w_ld_even = 1'b1;
               end else if (w_is_sdr || w_is_bram) begin
                  w_pend_set  = 1'b1;
                  w_state_nxt = S_REQ;
               end else begin
                  w_err_rng = 1'b1;
               end
            end else if (!ioctl_download) begin
               w_state_nxt = S_FLUSH;
            end
         end
         S_REQ, S_FLUSH: begin
            if (r_sdr_req && sdr_rdy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // SDRAM word assembly and request handshake.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_sdr_addr <= '0;
         r_sdr_data <= '0;
         r_sdr_be   <= '0;
         r_sdr_req  <= 1'b0;
      end else begin
         if (w_ld_even) begin
            r_sdr_addr <= {w_b_addr[24:1], 1'b0};
            r_sdr_data <= {8'h00, w_b_data};
            r_sdr_be   <= 2'b01;
         end else if (w_ld_odd) begin
            r_sdr_addr <= {w_b_addr[24:1], 1'b0};
            r_sdr_data <= {w_b_data, 8'h00};
            r_sdr_be   <= 2'b10;
         end else if (w_merge) begin
            r_sdr_data[15:8] <= w_b_data;
            r_sdr_be         <= 2'b11;
         end
         if ((r_state == S_REQ) || (r_state == S_FLUSH)) r_sdr_req <= !(r_sdr_req && sdr_rdy);
         else                                            r_sdr_req <= 1'b0;
      end
   end

   // Byte parked while the held partial word is being written out.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
      end else if (w_pend_set) begin
         r_pend      <= 1'b1;
         r_pend_addr <= ioctl_addr;
         r_pend_data <= ioctl_data;
      end else if (w_pend_clr) begin
         r_pend <= 1'b0;
      end
   end

   // BRAM byte write pulse; select is forced to zero outside the pulse.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_bram_wr   <= 1'b0;
         r_bram_cs   <= '0;
         r_bram_addr <= '0;
         r_bram_data <= '0;
      end else begin
         r_bram_wr <= w_do_bram;
         r_bram_cs <= w_do_bram ? w_cs : '0;
         if (w_do_bram) begin
            r_bram_addr <= w_off[BRAM_AW-1:0];
            r_bram_data <= w_b_data;
         end
      end
   end

   // Download edge tracking, completion pulse and sticky error flags.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_dl_d      <= 1'b0;
         r_done_arm  <= 1'b0;
         r_load_done <= 1'b0;
         r_err       <= '0;
      end else begin
         r_dl_d      <= ioctl_download;
         r_load_done <= w_done;
         if (w_dl_fall)                  r_done_arm <= 1'b1;
         else if (w_dl_rise || w_done)   r_done_arm <= 1'b0;
         r_err <= (w_dl_rise ? 2'b00 : r_err) | {w_drop, w_err_rng};
      end
   end

   assign ioctl_wait = w_wait;
   assign sdr_addr   = r_sdr_addr;
   assign sdr_data   = r_sdr_data;
   assign sdr_be     = r_sdr_be;
   assign sdr_req    = r_sdr_req;
   assign bram_addr  = r_bram_addr;
   assign bram_data  = r_bram_data;
   assign bram_cs    = r_bram_cs;
   assign bram_wr    = r_bram_wr;
   assign load_done  = r_load_done;
   assign err        = r_err;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Directed bench for rom_stream_loader with default parameters.
module tb_rom_stream_loader;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wait;
   logic [24:0] sdr_addr;
   logic [15:0] sdr_data;
   logic [1:0]  sdr_be;
   logic        sdr_req;
   logic        sdr_rdy;
   logic [15:0] bram_addr;
   logic [7:0]  bram_data;
   logic [5:0]  bram_cs;
   logic        bram_wr;
   logic        load_done;
   logic [1:0]  err;

   int checks = 0;
   int errors = 0;
   int n_req  = 0;
   int n_done = 0;
   logic req_q = 1'b0;
   int base_req;
   int base_done;

   rom_stream_loader dut (
      .CLK(CLK), .RSTn(RSTn),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
      .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
      .sdr_req(sdr_req), .sdr_rdy(sdr_rdy),
      .bram_addr(bram_addr), .bram_data(bram_data), .bram_cs(bram_cs), .bram_wr(bram_wr),
      .load_done(load_done), .err(err)
   );

   always #5 CLK = ~CLK;

   // Counts request rising edges and load_done pulses.
   always @(posedge CLK) begin
      req_q <= sdr_req;
      if (sdr_req && !req_q) n_req <= n_req + 1;
      if (load_done) n_done <= n_done + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   // Waits for a request, checks the word, holds it a cycle, then completes it.
   task automatic serve(input string tag, input logic [24:0] ea, input logic [15:0] ed,
                        input logic [1:0] eb, input logic lo_only);
      int n = 0;
      while (sdr_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, " req"}, 32'(sdr_req), 32'd1);
      chk({tag, " addr"}, 32'(sdr_addr), 32'(ea));
      if (lo_only) chk({tag, " data_lo"}, 32'(sdr_data[7:0]), 32'(ed[7:0]));
      else         chk({tag, " data"}, 32'(sdr_data), 32'(ed));
      chk({tag, " be"}, 32'(sdr_be), 32'(eb));
      tick();
      chk({tag, " hold_addr"}, 32'(sdr_addr), 32'(ea));
      chk({tag, " hold_req"}, 32'(sdr_req), 32'd1);
      sdr_rdy = 1'b1;
      tick();
      sdr_rdy = 1'b0;
      chk({tag, " req_drop"}, 32'(sdr_req), 32'd0);
   endtask

   initial begin
      RSTn = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_data = '0;
      sdr_rdy = 1'b0;
      tick();
      tick();
      chk("rst sdr_req", 32'(sdr_req), 32'd0);
      chk("rst sdr_addr", 32'(sdr_addr), 32'd0);
      chk("rst wait", 32'(ioctl_wait), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst bram_cs", 32'(bram_cs), 32'd0);
      RSTn = 1'b1;
      tick();

      // Full word 0x2211 at 0; stray rdy while req is still low is ignored.
      ioctl_download = 1'b1;
      tick();
      base_req = n_req;
      ioctl_addr = 25'h0; ioctl_data = 8'h11; ioctl_wr = 1'b1;
      tick();
      chk("w0 hold wait", 32'(ioctl_wait), 32'd0);
      ioctl_addr = 25'h1; ioctl_data = 8'h22;
      tick();
      ioctl_wr = 1'b0;
      chk("w0 wait", 32'(ioctl_wait), 32'd1);
      chk("w0 req_delay", 32'(sdr_req), 32'd0);
      sdr_rdy = 1'b1;
      tick();
      sdr_rdy = 1'b0;
      chk("w0 rdy_ignored", 32'(sdr_req), 32'd1);
      serve("w0", 25'h0, 16'h2211, 2'b11, 1'b0);
      chk("w0 wait_low", 32'(ioctl_wait), 32'd0);
      tick();
      chk("w0 one_write", 32'(n_req - base_req), 32'd1);

      // Partial word flushed on end of download, then one load_done.
      base_done = n_done;
      send(25'h4, 8'hAB);
      ioctl_download = 1'b0;
      tick();
      chk("flush wait", 32'(ioctl_wait), 32'd1);
      serve("flush", 25'h4, 16'h00AB, 2'b01, 1'b1);
      chk("flush done_early", 32'(load_done), 32'd0);
      tick();
      chk("flush done", 32'(load_done), 32'd1);
      tick();
      tick();
      chk("flush done_once", 32'(n_done - base_done), 32'd1);

      // Different word while holding: partial write first, new byte then held.
      ioctl_download = 1'b1;
      tick();
      send(25'h2, 8'h01);
      send(25'h8, 8'h02);
      serve("pw", 25'h2, 16'h0001, 2'b01, 1'b0);
      chk("pw pend_wait", 32'(ioctl_wait), 32'd1);
      tick();
      chk("pw held_addr", 32'(sdr_addr), 32'h8);
      chk("pw held_data", 32'(sdr_data), 32'h0002);
      chk("pw held_be", 32'(sdr_be), 32'd1);
      chk("pw held_wait", 32'(ioctl_wait), 32'd0);
      send(25'h9, 8'h03);
      serve("pw2", 25'h8, 16'h0302, 2'b11, 1'b0);

      // Last SDRAM byte (odd) goes straight out as a high-byte write.
      send(25'hFFFFF, 8'h77);
      serve("top", 25'hFFFFE, 16'h7700, 2'b10, 1'b0);

      // BRAM writes: region 2 offset 3, then last byte of region 5.
      base_req = n_req;
      send(25'h120003, 8'h5A);
      chk("br2 wr", 32'(bram_wr), 32'd1);
      chk("br2 cs", 32'(bram_cs), 32'b000100);
      chk("br2 addr", 32'(bram_addr), 32'h0003);
      chk("br2 data", 32'(bram_data), 32'h5A);
      tick();
      chk("br2 wr_off", 32'(bram_wr), 32'd0);
      chk("br2 cs_off", 32'(bram_cs), 32'd0);
      send(25'h15FFFF, 8'hC3);
      chk("br5 cs", 32'(bram_cs), 32'b100000);
      chk("br5 addr", 32'(bram_addr), 32'hFFFF);
      tick();
      chk("br no_req", 32'(n_req - base_req), 32'd0);

      // Out of range, then a strobe during wait.
      send(25'h160000, 8'h99);
      chk("oor err", 32'(err), 32'd1);
      chk("oor bram_wr", 32'(bram_wr), 32'd0);
      chk("oor req", 32'(sdr_req), 32'd0);
      send(25'h10, 8'h10);
      send(25'h13, 8'h11);
      chk("wv wait", 32'(ioctl_wait), 32'd1);
      send(25'h20, 8'h55);
      chk("wv err", 32'(err), 32'd3);
      serve("wv1", 25'h10, 16'h0010, 2'b01, 1'b0);
      serve("wv2", 25'h12, 16'h1100, 2'b10, 1'b0);
      chk("wv err_sticky", 32'(err), 32'd3);

      // End of load from IDLE: load_done two cycles after the edge.
      ioctl_download = 1'b0;
      tick();
      chk("idle done_early", 32'(load_done), 32'd0);
      tick();
      chk("idle done", 32'(load_done), 32'd1);
      send(25'h120000, 8'h66);
      chk("nodl ignored", 32'(bram_wr), 32'd0);
      ioctl_download = 1'b1;
      tick();
      chk("rise err_clr", 32'(err), 32'd0);

      // Reset in the middle of a request.
      send(25'h170000, 8'hEE);
      chk("oor7 err", 32'(err), 32'd1);
      send(25'h31, 8'h21);
      tick();
      chk("mid req", 32'(sdr_req), 32'd1);
      base_req = n_req;
      RSTn = 1'b0;
      #1;
      chk("arst req", 32'(sdr_req), 32'd0);
      chk("arst addr", 32'(sdr_addr), 32'd0);
      chk("arst data", 32'(sdr_data), 32'd0);
      chk("arst be", 32'(sdr_be), 32'd0);
      chk("arst wait", 32'(ioctl_wait), 32'd0);
      chk("arst err", 32'(err), 32'd0);
      chk("arst bram_addr", 32'(bram_addr), 32'd0);
      chk("arst bram_data", 32'(bram_data), 32'd0);
      chk("arst done", 32'(load_done), 32'd0);
      tick();
      tick();
      RSTn = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("post req", 32'(sdr_req), 32'd0);
      chk("post no_req", 32'(n_req - base_req), 32'd0);
      chk("post wait", 32'(ioctl_wait), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
